mod10_chain_ctrl: RTL and testbench

Controller and arbiter for a synchronous chain of NDIG decade (mod-10, BCD) stages. Two requesters share the chain through a round-robin arbiter and issue CLEAR / LOAD / START / STOP commands. An internal FSM gates counting on a `tick` qualifier. This block replaces free-running ripple decade counters wherever software-visible, multi-owner timing counts are needed; all state changes occur on one clock edge.

---
 rtl/mod10_chain_ctrl_if.sv | 36 +++
 rtl/mod10_chain_ctrl.sv | 154 +++++++++++++++
 tb/tb_mod10_chain_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod10_chain_ctrl_if.sv
// ============================================================================
// Module      : mod10_chain_ctrl_if
// Description : Command/handshake and count-status bundle for mod10_chain_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mod10_chain_ctrl_if #(
    parameter int NDIG = 4
);
    logic [1:0]          req;
    logic [1:0]          cmd0;
    logic [1:0]          cmd1;
    logic [4*NDIG-1:0]   data0;
    logic [4*NDIG-1:0]   data1;
    logic                tick;
    logic                dir;
    logic [1:0]          gnt;
    logic [4*NDIG-1:0]   count;
    logic                running;
    logic                wrap;
    logic                err;

    modport master (
        output req, cmd0, cmd1, data0, data1, tick, dir,
        input  gnt, count, running, wrap, err
    );

    modport slave (
        input  req, cmd0, cmd1, data0, data1, tick, dir,
        output gnt, count, running, wrap, err
    );
endinterface

`default_nettype wire

// File: rtl/mod10_chain_ctrl.sv
// ============================================================================
// Module      : mod10_chain_ctrl
// Description : Two-requester round-robin controller for an NDIG-digit BCD
//               counter chain. Define MOD10_CTRL_DOWN_EN for dir-selected
//               down counting.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mod10_chain_ctrl #(
    parameter int NDIG = 4
) (
    input  wire logic          clk1,
    input  wire logic          r,
    mod10_chain_ctrl_if.slave  bus
);

    localparam int         c_CW        = 4 * NDIG;
    localparam logic [1:0] c_CMD_CLEAR = 2'b00;
    localparam logic [1:0] c_CMD_LOAD  = 2'b01;
    localparam logic [1:0] c_CMD_START = 2'b10;
    localparam logic [1:0] c_CMD_STOP  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [1:0]        r_gnt;
    logic              r_last;
    logic [c_CW-1:0]   r_count;
    logic              r_running;
    logic              r_wrap;
    logic              r_err;

    logic [1:0]        w_elig;
    logic              w_grant;
    logic              w_sel;
    logic [1:0]        w_cmd;
    logic [c_CW-1:0]   w_data;
    logic [NDIG-1:0]   w_ld_ok;
    logic [NDIG:0]     w_low9;
    logic [c_CW-1:0]   w_inc;
    logic [c_CW-1:0]   w_step;
    logic              w_step_wrap;

    // A requester is ineligible while its own grant is still showing.
    assign w_elig = bus.req & ~r_gnt;

    always_comb begin
        w_grant = 1'b0;
        w_sel   = 1'b0;
        unique case (w_elig)
            2'b01:   begin w_grant = 1'b1; w_sel = 1'b0;    end
            2'b10:   begin w_grant = 1'b1; w_sel = 1'b1;    end
            2'b11:   begin w_grant = 1'b1; w_sel = ~r_last; end
            default: begin w_grant = 1'b0; w_sel = 1'b0;    end
        endcase
    end

    assign w_cmd  = w_sel ? bus.cmd1  : bus.cmd0;
    assign w_data = w_sel ? bus.data1 : bus.data0;

    assign w_low9[0] = 1'b1;

    generate
        for (genvar k = 0; k < NDIG; k++) begin : g_digit
            logic [3:0] w_d;
            assign w_d            = r_count[4*k +: 4];
            assign w_low9[k+1]    = w_low9[k] & (w_d == 4'd9);
            assign w_inc[4*k +: 4] = w_low9[k] ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) : w_d;
            assign w_ld_ok[k]     = (w_data[4*k +: 4] <= 4'd9);
        end
    endgenerate

`ifdef MOD10_CTRL_DOWN_EN
    logic [NDIG:0]     w_low0;
    logic [c_CW-1:0]   w_dec;

    assign w_low0[0] = 1'b1;

    generate
        for (genvar k = 0; k < NDIG; k++) begin : g_borrow
            logic [3:0] w_d;
            assign w_d             = r_count[4*k +: 4];
            assign w_low0[k+1]     = w_low0[k] & (w_d == 4'd0);
            assign w_dec[4*k +: 4] = w_low0[k] ? ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1) : w_d;
        end
    endgenerate

    assign w_step      = bus.dir ? w_dec        : w_inc;
    assign w_step_wrap = bus.dir ? w_low0[NDIG] : w_low9[NDIG];
`else
    logic w_unused_dir;

    assign w_unused_dir = bus.dir;
    assign w_step       = w_inc;
    assign w_step_wrap  = w_low9[NDIG];
`endif

    // A granted command takes the edge; any coincident tick is dropped.
    always_ff @(posedge clk1 or posedge r) begin
        if (r) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 2'b00;
            r_last    <= 1'b1;
            r_count   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_gnt  <= 2'b00;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            if (w_grant) begin
                r_gnt  <= w_sel ? 2'b10 : 2'b01;
                r_last <= w_sel;
                unique case (w_cmd)
                    c_CMD_CLEAR: r_count <= '0;
                    c_CMD_LOAD: begin
                        if (&w_ld_ok) begin
                            r_count <= w_data;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    c_CMD_START: begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                    c_CMD_STOP: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                    default: r_count <= r_count;
                endcase
            end else if ((r_state == ST_RUN) && bus.tick) begin
                r_count <= w_step;
                r_wrap  <= w_step_wrap;
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.count   = r_count;
    assign bus.running = r_running;
    assign bus.wrap    = r_wrap;
    assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mod10_chain_ctrl.sv
// ============================================================================
// Module      : tb_mod10_chain_ctrl
// Description : Directed plus randomized bench for mod10_chain_ctrl against an
//               integer-valued reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mod10_chain_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int MAXV = 9999;

    localparam logic [1:0] CLEAR = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] START = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    logic clk1 = 1'b0;
    logic r    = 1'b1;

    mod10_chain_ctrl_if #(.NDIG(NDIG)) bus ();

    mod10_chain_ctrl #(.NDIG(NDIG)) dut (
        .clk1 (clk1),
        .r    (r),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count held as a plain integer.
    int         m_count;
    bit         m_run;
    logic [1:0] m_gnt;
    int         m_last;
    logic       e_wrap;
    logic       e_err;

    // Requester agents; mode 0 = drop after grant, 1 = hold, 2 = random.
    logic [1:0]   p_req;
    logic [1:0]   p_cmd [2];
    logic [W-1:0] p_data[2];
    int           mode;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] b;
        int t;
        t = v;
        for (int k = 0; k < NDIG; k++) begin
            b[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    function automatic bit bcd_ok(logic [W-1:0] d);
        for (int k = 0; k < NDIG; k++)
            if (d[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_val(logic [W-1:0] d);
        int v;
        v = 0;
        for (int k = NDIG - 1; k >= 0; k--) v = v * 10 + int'(d[4*k +: 4]);
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_run   = 1'b0;
        m_gnt   = 2'b00;
        m_last  = -1;
        e_wrap  = 1'b0;
        e_err   = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0]   elig;
        logic [1:0]   c;
        logic [W-1:0] d;
        logic         down;
        int           sel;
        down = 1'b0;
`ifdef MOD10_CTRL_DOWN_EN
        down = bus.dir;
`endif
        elig = bus.req & ~m_gnt;
        sel  = -1;
        if (elig == 2'b11)  sel = (m_last == 0) ? 1 : 0;
        else if (elig[0])   sel = 0;
        else if (elig[1])   sel = 1;
        m_gnt  = 2'b00;
        e_wrap = 1'b0;
        e_err  = 1'b0;
        if (sel >= 0) begin
            m_gnt[sel] = 1'b1;
            m_last     = sel;
            c = (sel == 1) ? bus.cmd1  : bus.cmd0;
            d = (sel == 1) ? bus.data1 : bus.data0;
            case (c)
                CLEAR:   m_count = 0;
                LOAD:    if (bcd_ok(d)) m_count = bcd_val(d); else e_err = 1'b1;
                START:   m_run = 1'b1;
                default: m_run = 1'b0;
            endcase
        end else if (m_run && bus.tick) begin
            if (down) begin
                if (m_count == 0) begin m_count = MAXV; e_wrap = 1'b1; end
                else m_count = m_count - 1;
            end else begin
                if (m_count == MAXV) begin m_count = 0; e_wrap = 1'b1; end
                else m_count = m_count + 1;
            end
        end
    endtask

    task automatic compare_all();
        check("count",   32'(bus.count),   32'(to_bcd(m_count)));
        check("gnt",     32'(bus.gnt),     32'(m_gnt));
        check("running", 32'(bus.running), 32'(m_run));
        check("wrap",    32'(bus.wrap),    32'(e_wrap));
        check("err",     32'(bus.err),     32'(e_err));
    endtask

    task automatic new_cmd(int i);
        int s;
        logic [W-1:0] raw;
        p_req[i] = 1'b1;
        s = $urandom_range(0, 9);
        p_cmd[i] = (s == 0) ? CLEAR : (s < 4) ? LOAD : (s < 7) ? START : STOP;
        s = $urandom_range(0, 7);
        raw = W'($urandom);
        if (s == 0)      p_data[i] = raw;
        else if (s == 1) p_data[i] = to_bcd(MAXV - $urandom_range(0, 3));
        else             p_data[i] = to_bcd($urandom_range(0, MAXV));
    endtask

    task automatic agents_update();
        for (int i = 0; i < 2; i++) begin
            if (m_gnt[i]) begin
                if (mode == 0) p_req[i] = 1'b0;
                else if (mode == 2) begin
                    if ($urandom_range(0, 1) == 1) new_cmd(i);
                    else p_req[i] = 1'b0;
                end
            end else if (mode == 2) begin
                if (p_req[i] && $urandom_range(0, 15) == 0) p_req[i] = 1'b0;
                else if (!p_req[i] && $urandom_range(0, 2) == 0) new_cmd(i);
            end
        end
    endtask

    task automatic cycle();
        bus.req   = p_req;
        bus.cmd0  = p_cmd[0];
        bus.cmd1  = p_cmd[1];
        bus.data0 = p_data[0];
        bus.data1 = p_data[1];
        model_step();
        @(posedge clk1);
        #1;
        compare_all();
        agents_update();
    endtask

    task automatic issue(int i, logic [1:0] c, logic [W-1:0] d);
        int n;
        n = 0;
        p_req[i]  = 1'b1;
        p_cmd[i]  = c;
        p_data[i] = d;
        do begin
            cycle();
            n++;
        end while (!m_gnt[i] && n < 8);
        if (!m_gnt[i]) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic async_reset();
        @(posedge clk1);
        #3;
        r = 1'b1;
        #1;
        model_reset();
        compare_all();
        p_req   = 2'b00;
        bus.req = 2'b00;
        @(posedge clk1);
        #1;
        r = 1'b0;
    endtask

    initial begin
        p_req     = 2'b00;
        p_cmd[0]  = CLEAR;
        p_cmd[1]  = CLEAR;
        p_data[0] = '0;
        p_data[1] = '0;
        mode      = 0;
        bus.req   = 2'b00;
        bus.cmd0  = CLEAR;
        bus.cmd1  = CLEAR;
        bus.data0 = '0;
        bus.data1 = '0;
        bus.tick  = 1'b0;
        bus.dir   = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(posedge clk1);
        #1;
        r = 1'b0;

        // Idle with tick high, then count up after START.
        bus.tick = 1'b1;
        repeat (3) cycle();
        issue(0, START, '0);
        repeat (3) cycle();

        // Carry ripple and roll-over.
        issue(0, LOAD, 16'h0998);
        repeat (2) cycle();
        issue(0, LOAD, 16'h9999);
        repeat (2) cycle();

        // Both requesters held, then only requester 1 held.
        mode     = 1;
        p_cmd[0] = CLEAR;
        p_cmd[1] = CLEAR;
        p_req    = 2'b11;
        repeat (6) cycle();
        p_req[0] = 1'b0;
        repeat (6) cycle();
        p_req = 2'b00;
        mode  = 0;

        // STOP against a coincident tick, then frozen count.
        repeat (2) cycle();
        issue(1, STOP, '0);
        repeat (3) cycle();

        // Rejected LOAD.
        issue(0, LOAD, 16'h12A4);
        cycle();

        // Reset in the middle of a run.
        issue(0, START, '0);
        repeat (4) cycle();
        async_reset();

`ifdef MOD10_CTRL_DOWN_EN
        bus.dir = 1'b1;
        issue(0, LOAD, 16'h0001);
        issue(0, START, '0);
        repeat (3) cycle();
        bus.dir = 1'b0;
`endif

        mode = 2;
        repeat (3000) begin
            bus.tick = ($urandom_range(0, 3) != 0);
            bus.dir  = 1'($urandom_range(0, 1));
            cycle();
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
